bram_bus_adapter: RTL and testbench
===================================

// Module: bram_bus_adapter
// PURPOSE
//   Initiator-side front end for a synchronous block RAM (1-cycle registered read, sync write).
//   Converts a valid/ready byte-addressed request/response bus (core fetch/LSU side) into RAM port
//   drive. Sequences 1-cycle read latency; partial-word writes done as read-modify-write.
//   Sits between the core memory interface and one RAM instance; one transaction in flight.
// PARAMETERS
//   SIZE        1024  RAM size in bytes; multiple of WIDTH/8
//   WIDTH       32    data word width in bits; multiple of 8, >= 8
//   ADDR_WIDTH  32    request byte-address width
//   (derived) NB = WIDTH/8, OFS = $clog2(NB), AW = $clog2(SIZE/NB)
// PORTS
//   clk              in   1           clock, rising edge
//   reset            in   1           asynchronous, active-high
//   req_valid        in   1           request present
//   req_ready        out  1           adapter accepts request this cycle
//   req_write        in   1           1 = write, 0 = read
//   req_addr         in   ADDR_WIDTH  byte address; low OFS bits ignored (word aligned)
//   req_wdata        in   WIDTH       write data, byte lane i = bits [8i+7:8i]
//   req_wstrb        in   NB          byte write enables
//   resp_valid       out  1           response present
//   resp_ready       in   1           consumer takes response
//   resp_rdata       out  WIDTH       read data; 0 for writes
//   resp_error       out  1           address out of range (see CONFIGURATION)
//   ram_write_en     out  1           RAM write enable
//   ram_write_address out AW          RAM write word index
//   ram_write_data   out  WIDTH       RAM write data
//   ram_read_address out AW          RAM read word index
//   ram_read_data    in   WIDTH       RAM registered read data (valid cycle after address)
// BEHAVIOUR
//   Reset: state IDLE; resp_valid=0, resp_rdata=0, resp_error=0; ram_write_en=0 (state-decoded).
//   Word index idx = req_addr[OFS +: AW]. req_ready = (state==IDLE). Accept = req_valid & req_ready.
//   States: IDLE, RD_WAIT, MERGE, RESP.
//   IDLE, accept read: ram_read_address=idx same cycle -> RD_WAIT.
//   IDLE, accept write, wstrb all ones: ram_write_en=1, address idx, data req_wdata same cycle -> RESP.
//   IDLE, accept write, wstrb partial: ram_read_address=idx; latch idx/wdata/wstrb -> MERGE.
//   IDLE, accept write, wstrb==0: no RAM access -> RESP.
//   RD_WAIT: resp_rdata <= ram_read_data -> RESP.
//   MERGE: ram_write_en=1, data = per byte wstrb[i] ? wdata lane : ram_read_data lane -> RESP.
//   RESP: resp_valid=1, resp_rdata/resp_error held stable until resp_ready=1 -> IDLE.
//   Latency (accept cycle N): full write / zero-strobe resp_valid at N+1; read, partial write N+2.
//   Throughput: no accept while in RESP; back-to-back best case 1 txn per 2 cycles (full write).
//   Read after write of same word returns new data (write completes before RESP).
//   ram_* address/data outputs are don't-care while ram_write_en=0 / outside read-issue cycles.
//   Reset mid-transaction: txn dropped, no RAM write issued (MERGE write suppressed), no response.
// CONFIGURATION
//   BRAM_ADAPTER_RANGE_CHECK_EN defined: req_addr >= SIZE -> resp_error=1, no RAM write,
//     resp_rdata=0; latency unchanged per request type.
//   Not defined: upper address bits ignored (idx wraps modulo SIZE/NB); resp_error tied 0.
// STRUCTURE
//   Package bram_adapter_pkg: state_t enum {IDLE,RD_WAIT,MERGE,RESP}; function
//     byte_merge(old, new, strb) parameterised by NB via caller-sized vectors.
//   No sub-module: single FSM + datapath regs.
// TESTING (SIZE=1024, WIDTH=32)
//   Full write 0x0000_0010 <- 0xDEADBEEF strb 4'hF, then read 0x10 -> resp 0xDEADBEEF, N+1 / N+2.
//   Partial write 0x10 data 0x0000_5500 strb 4'b0010 over 0xDEADBEEF -> read gives 0xDEAD55EF.
//   resp_ready held 0 for 5 cycles -> resp_valid, resp_rdata stable; req_ready=0 throughout.
//   Reset asserted in MERGE -> ram_write_en never asserted; reread word unchanged, resp_valid=0.
//   Read 0x0000_0400: with _EN resp_error=1 rdata 0; without, returns word at 0x0 (wrap).
//   Unaligned read 0x13 -> same data as 0x10; wstrb=0 write -> RESP at N+1, RAM unchanged.

Source files
------------

// File: rtl/bram_adapter_pkg.sv
// Shared types and helpers for the block-RAM bus adapter.
package bram_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        MERGE   = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Widest word the merge helper handles, in bytes; callers zero-extend
    // their narrower vectors into this width and keep the low WIDTH bits.
    localparam int MAX_NB = 128;
    localparam int MAX_W  = MAX_NB * 8;

    // Byte-lane merge: lanes with a set strobe take the new data, others keep the old word.
    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]  old_word,
        input logic [MAX_W-1:0]  new_word,
        input logic [MAX_NB-1:0] strb
    );
        logic [MAX_W-1:0] result;
        for (int i = 0; i < MAX_NB; i++) begin
            result[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/bram_bus_adapter.sv
// Valid/ready request/response front end for a synchronous block RAM with a
// one-cycle registered read. Full-word writes go straight to the RAM; partial
// writes are done as read-modify-write. One transaction in flight at a time.
// Optional build macro: BRAM_ADAPTER_RANGE_CHECK_EN flags addresses >= SIZE
// as errors (no RAM write, zero read data); without it the word index wraps.
module bram_bus_adapter
    import bram_adapter_pkg::*;
#(
    parameter  int SIZE       = 1024,
    parameter  int WIDTH      = 32,
    parameter  int ADDR_WIDTH = 32,
    localparam int NB         = WIDTH / 8,
    localparam int OFS        = $clog2(NB),
    localparam int AW         = $clog2(SIZE / NB)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    input  logic [NB-1:0]         req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_rdata,
    output logic                  resp_error,
    output logic                  ram_write_en,
    output logic [AW-1:0]         ram_write_address,
    output logic [WIDTH-1:0]      ram_write_data,
    output logic [AW-1:0]         ram_read_address,
    input  logic [WIDTH-1:0]      ram_read_data
);

    state_t            state;
    state_t            next_state;
    logic [AW-1:0]     idx;
    logic              accept;
    logic              out_of_range;
    logic [AW-1:0]     idx_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [NB-1:0]     wstrb_q;
    logic              err_q;
    logic [WIDTH-1:0]  resp_rdata_q;
    logic              resp_error_q;
    logic [MAX_W-1:0]  old_ext;
    logic [MAX_W-1:0]  new_ext;
    logic [MAX_NB-1:0] strb_ext;
    logic [MAX_W-1:0]  merge_ext;
    logic [WIDTH-1:0]  merged;
    logic              unused_ok;

    assign idx        = req_addr[OFS +: AW];
    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

`ifdef BRAM_ADAPTER_RANGE_CHECK_EN
    assign out_of_range = (req_addr >= ADDR_WIDTH'(SIZE));
`else
    assign out_of_range = 1'b0;
`endif

    // Upper request-address bits and the unused top of the merge result are not needed.
    assign unused_ok = ^{req_addr, merge_ext};

    // Widen the latched write and the RAM read word into the merge helper's width.
    always_comb begin
        old_ext  = '0;
        new_ext  = '0;
        strb_ext = '0;
        old_ext[WIDTH-1:0] = ram_read_data;
        new_ext[WIDTH-1:0] = wdata_q;
        strb_ext[NB-1:0]   = wstrb_q;
        merge_ext = byte_merge(old_ext, new_ext, strb_ext);
        merged    = merge_ext[WIDTH-1:0];
    end

    // State register; an asserted reset drops any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and RAM port drive, decoded from the current state.
    always_comb begin
        next_state        = state;
        ram_write_en      = 1'b0;
        ram_write_address = idx;
        ram_write_data    = req_wdata;
        ram_read_address  = idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_write) begin
                        next_state = RD_WAIT;
                    end else if (req_wstrb == '0) begin
                        next_state = RESP;
                    end else if (&req_wstrb) begin
                        ram_write_en = !out_of_range;
                        next_state   = RESP;
                    end else begin
                        next_state = MERGE;
                    end
                end
            end
            RD_WAIT: begin
                next_state = RESP;
            end
            MERGE: begin
                ram_write_en      = !err_q;
                ram_write_address = idx_q;
                ram_write_data    = merged;
                next_state        = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch the accepted request and build the response, which then holds through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q        <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            err_q        <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx_q        <= idx;
                        wdata_q      <= req_wdata;
                        wstrb_q      <= req_wstrb;
                        err_q        <= out_of_range;
                        resp_error_q <= out_of_range;
                        resp_rdata_q <= '0;
                    end
                end
                RD_WAIT: begin
                    resp_rdata_q <= err_q ? '0 : ram_read_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_bus_adapter.sv
// Testbench for bram_bus_adapter with a behavioural registered-read block RAM.
// Honours BRAM_ADAPTER_RANGE_CHECK_EN when the build defines it.
module tb_bram_bus_adapter;

    localparam int SIZE  = 1024;
    localparam int WIDTH = 32;
    localparam int NB    = WIDTH / 8;
    localparam int AW    = $clog2(SIZE / NB);

`ifdef BRAM_ADAPTER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [31:0]      req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic [NB-1:0]    req_wstrb;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_error;
    logic             ram_write_en;
    logic [AW-1:0]    ram_write_address;
    logic [WIDTH-1:0] ram_write_data;
    logic [AW-1:0]    ram_read_address;
    logic [WIDTH-1:0] ram_read_data;

    logic [WIDTH-1:0] mem [SIZE/NB];

    int checks = 0;
    int errors = 0;
    bit we_armed = 0;
    bit we_seen  = 0;

    bram_bus_adapter #(.SIZE(SIZE), .WIDTH(WIDTH), .ADDR_WIDTH(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_wstrb         (req_wstrb),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_rdata        (resp_rdata),
        .resp_error        (resp_error),
        .ram_write_en      (ram_write_en),
        .ram_write_address (ram_write_address),
        .ram_write_data    (ram_write_data),
        .ram_read_address  (ram_read_address),
        .ram_read_data     (ram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural block RAM: synchronous write, one-cycle registered read.
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_write_address] <= ram_write_data;
        ram_read_data <= mem[ram_read_address];
    end

    // Watch for any RAM write while armed (reset-during-merge sequence).
    always @(posedge clk) begin
        if (we_armed && ram_write_en) we_seen = 1'b1;
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One complete transaction: drive request, wait (bounded) for response, accept it.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, output logic [31:0] rdata,
                                 output bit err, output int lat);
        @(negedge clk);
        checkOutput($sformatf("req_ready before addr 0x%08h", addr), {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_error;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    bit          er;
    int          lt;
    logic [31:0] exp10;

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < SIZE/NB; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset req_ready",    {31'b0, req_ready},    32'd1);
        checkOutput("reset resp_valid",   {31'b0, resp_valid},   32'd0);
        checkOutput("reset resp_rdata",   resp_rdata,            32'd0);
        checkOutput("reset resp_error",   {31'b0, resp_error},   32'd0);
        checkOutput("reset ram_write_en", {31'b0, ram_write_en}, 32'd0);
        reset = 1'b0;

        // Directed vectors, applied in order against a zero-initialised RAM
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 2});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'h0000_5500, 4'h2, 32'h0, 1'b0, 2});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_55EF, 1'b0, 2});
        vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'hDEAD_55EF, 1'b0, 2});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 1});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_55EF, 1'b0, 2});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1});
        vecs.push_back('{1'b0, 32'h0000_0400, 32'h0,         4'h0, RC ? 32'h0 : 32'h1234_5678, RC, 2});
        vecs.push_back('{1'b1, 32'h0000_0404, 32'hAAAA_AAAA, 4'hF, 32'h0, RC, 1});
        vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,         4'h0, RC ? 32'h0 : 32'hAAAA_AAAA, 1'b0, 2});
        vecs.push_back('{1'b1, 32'h0000_03FC, 32'h1122_3344, 4'h9, 32'h0, 1'b0, 2});
        vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'h1100_0044, 1'b0, 2});
        vecs.push_back('{1'b1, 32'h0000_0410, 32'h0000_CC00, 4'h2, 32'h0, RC, 2});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, RC ? 32'hDEAD_55EF : 32'hDEAD_CCEF, 1'b0, 2});
        exp10 = RC ? 32'hDEAD_55EF : 32'hDEAD_CCEF;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, lt);
            checkOutput($sformatf("vec%0d rdata", i),   rd,           vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d error", i),   {31'b0, er},  {31'b0, vecs[i].exp_err});
            checkOutput($sformatf("vec%0d latency", i), lt,           vecs[i].exp_lat);
        end

        // Response backpressure: outputs hold while resp_ready stays low
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lt = 1;
        while (!resp_valid && lt < 10) begin
            @(posedge clk);
            @(negedge clk);
            lt++;
        end
        checkOutput("stall latency", lt, 32'd2);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("stall%0d resp_valid", c), {31'b0, resp_valid}, 32'd1);
            checkOutput($sformatf("stall%0d resp_rdata", c), resp_rdata, exp10);
            checkOutput($sformatf("stall%0d req_ready", c),  {31'b0, req_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("stall released resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("stall released req_ready",  {31'b0, req_ready},  32'd1);

        // Reset while in MERGE: the write must never reach the RAM
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'h0000_00AA;
        req_wstrb = 4'h1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        we_seen   = 1'b0;
        we_armed  = 1'b1;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        we_armed = 1'b0;
        checkOutput("merge reset ram_write_en seen", {31'b0, we_seen},    32'd0);
        checkOutput("merge reset resp_valid",        {31'b0, resp_valid}, 32'd0);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, er, lt);
        checkOutput("merge reset reread", rd, exp10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
